// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven hour/minute setting controller for a wall clock.
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   btn_mode     in   debounced mode button level (async)
//   btn_inc      in   debounced increment button level (async)
//   cur_hour     in   live hour 0..23 from the clock datapath
//   cur_min      in   live minute 0..59 from the clock datapath
//   clock_hold   out  freezes datapath counting while setting
//   load_strobe  out  one-cycle load of load_hour/load_min into the datapath
//   load_hour    out  shadow hour
//   load_min     out  shadow minute
//   blink_hour   out  blank hour digits
//   blink_min    out  blank minute digits
//   tick_1hz     out  one-cycle pulse every TICK_DIV cycles
module clock_set_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       clock_hold,
    output logic       load_strobe,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic       blink_hour,
    output logic       blink_min,
    output logic       tick_1hz
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d, warm_q, warm_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic          phase_q, phase_d, hold_q, hold_d, strobe_q, strobe_d;
    logic          bh_q, bh_d, bm_q, bm_d;
    logic          mode_p, inc_p, in_set;

    // warm_q gates edge detection until the synchronizer holds three real
    // samples, so a button already held at reset release is not a press
    assign mode_p      = warm_q[2] & mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_p       = warm_q[2] & inc_sync_q[1] & ~inc_sync_q[2];
    assign tick_1hz    = pre_q == PW'(TICK_DIV - 1);
    assign clock_hold  = hold_q;
    assign load_strobe = strobe_q;
    assign load_hour   = hour_q;
    assign load_min    = min_q;
    assign blink_hour  = bh_q;
    assign blink_min   = bm_q;

    always_comb begin
        mode_sync_d = {mode_sync_q[1:0], btn_mode};
        inc_sync_d  = {inc_sync_q[1:0], btn_inc};
        warm_d      = {warm_q[1:0], 1'b1};
        pre_d       = tick_1hz ? '0 : pre_q + 1'b1;
        in_set      = (state_q == SET_HOUR) || (state_q == SET_MIN);
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        idle_d      = (mode_p | inc_p) ? '0 : (tick_1hz && in_set) ? idle_q + 1'b1 : idle_q;
        phase_d     = phase_q ^ tick_1hz;
        case (state_q)
            RUN: if (mode_p) begin
                state_d = SET_HOUR;
                hour_d  = cur_hour;
                min_d   = cur_min;
                phase_d = 1'b0;
            end
            SET_HOUR: if (mode_p) begin
                state_d = SET_MIN;
                phase_d = 1'b0;
            end else if (inc_p) begin
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else if (idle_q == IW'(TIMEOUT_S)) begin
                state_d = RUN;
            end
            SET_MIN: if (mode_p) begin
                state_d = COMMIT;
            end else if (inc_p) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end else if (idle_q == IW'(TIMEOUT_S)) begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // outputs registered from the next state so they align with state_q
        hold_d   = state_d != RUN;
        strobe_d = state_d == COMMIT;
        bh_d     = (state_d == SET_HOUR) && phase_d;
        bm_d     = (state_d == SET_MIN) && phase_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            warm_q      <= '0;
            pre_q       <= '0;
            idle_q      <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            phase_q     <= 1'b0;
            hold_q      <= 1'b0;
            strobe_q    <= 1'b0;
            bh_q        <= 1'b0;
            bm_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_sync_q <= mode_sync_d;
            inc_sync_q  <= inc_sync_d;
            warm_q      <= warm_d;
            pre_q       <= pre_d;
            idle_q      <= idle_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            strobe_q    <= strobe_d;
            bh_q        <= bh_d;
            bm_q        <= bm_d;
        end
    end
endmodule
